// File: rtl/i2s_tx.sv
// I2S transmitter: one-deep sample-pair buffer feeding left/right shifters, MSB one sclk after lrclk edge.
// Optional `I2S_TX_UNDERRUN_CNT_EN adds a saturating 16-bit underrun counter output.
module i2s_tx #(
    parameter int unsigned DATA_RES  = 24,
    parameter int unsigned SLOT_BITS = 32
) (
    input  logic                mclk,
    input  logic                reset,
    input  logic                next_sclk_fall,
    input  logic                next_lrclk_fall,
    input  logic                next_lrclk_rise,
    input  logic [DATA_RES-1:0] i_left,
    input  logic [DATA_RES-1:0] i_right,
    input  logic                i_valid,
    output logic                o_ready,
    output logic                o_sdata,
    output logic                o_frame_start,
`ifdef I2S_TX_UNDERRUN_CNT_EN
    output logic                o_underrun,
    output logic [15:0]         o_underrun_cnt
`else
    output logic                o_underrun
`endif
);

    localparam int unsigned CW = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DATA_RES-1:0] hold_left_q, hold_left_d;
    logic [DATA_RES-1:0] hold_right_q, hold_right_d;
    logic                hold_full_q, hold_full_d;
    logic [DATA_RES-1:0] left_sh_q, left_sh_d;
    logic [DATA_RES-1:0] right_sh_q, right_sh_d;
    logic                sdata_q, sdata_d;
    logic                frame_start_q, frame_start_d;
    logic                underrun_q, underrun_d;
    logic                accept;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [15:0]         underrun_cnt_q, underrun_cnt_d;
`endif

    assign accept = i_valid && !hold_full_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        hold_left_d   = hold_left_q;
        hold_right_d  = hold_right_q;
        hold_full_d   = hold_full_q;
        left_sh_d     = left_sh_q;
        right_sh_d    = right_sh_q;
        sdata_d       = sdata_q;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;

        unique case (state_q)
            SYNC:    if (next_lrclk_fall) state_d = LEFT;
            LEFT:    if (next_lrclk_rise) state_d = RIGHT;
                     else if (next_lrclk_fall) state_d = LEFT;
            RIGHT:   if (next_lrclk_fall) state_d = LEFT;
            default: state_d = SYNC;
        endcase

        // Commit reads the buffer state before this edge's accept, so a
        // same-cycle accept into an empty buffer still counts as an underrun.
        if (next_lrclk_fall) begin
            if (hold_full_q) begin
                left_sh_d     = hold_left_q;
                right_sh_d    = hold_right_q;
                hold_full_d   = 1'b0;
                frame_start_d = 1'b1;
            end else begin
                left_sh_d  = '0;
                right_sh_d = '0;
                underrun_d = 1'b1;
            end
        end

        if (accept) begin
            hold_left_d  = i_left;
            hold_right_d = i_right;
            hold_full_d  = 1'b1;
        end

        if (next_sclk_fall) begin
            if (next_lrclk_fall || next_lrclk_rise) begin
                cnt_d = '0;
            end else if (cnt_q != CW'(SLOT_BITS - 1)) begin
                cnt_d = cnt_q + CW'(1);
            end

            // Shifting left keeps the next bit to send at the MSB of the active shifter.
            if (state_d == SYNC || cnt_d == '0 || cnt_d > CW'(DATA_RES)) begin
                sdata_d = 1'b0;
            end else if (state_d == LEFT) begin
                sdata_d   = left_sh_q[DATA_RES-1];
                left_sh_d = {left_sh_q[DATA_RES-2:0], 1'b0};
            end else begin
                sdata_d    = right_sh_q[DATA_RES-1];
                right_sh_d = {right_sh_q[DATA_RES-2:0], 1'b0};
            end
        end
    end

`ifdef I2S_TX_UNDERRUN_CNT_EN
    always_comb begin
        underrun_cnt_d = underrun_cnt_q;
        if (underrun_d && underrun_cnt_q != '1) begin
            underrun_cnt_d = underrun_cnt_q + 16'd1;
        end
    end
`endif

    always_ff @(posedge mclk) begin
        if (reset) begin
            state_q       <= SYNC;
            cnt_q         <= CW'(SLOT_BITS - 1);
            hold_left_q   <= '0;
            hold_right_q  <= '0;
            hold_full_q   <= 1'b0;
            left_sh_q     <= '0;
            right_sh_q    <= '0;
            sdata_q       <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
`ifdef I2S_TX_UNDERRUN_CNT_EN
            underrun_cnt_q <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            hold_left_q   <= hold_left_d;
            hold_right_q  <= hold_right_d;
            hold_full_q   <= hold_full_d;
            left_sh_q     <= left_sh_d;
            right_sh_q    <= right_sh_d;
            sdata_q       <= sdata_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
`ifdef I2S_TX_UNDERRUN_CNT_EN
            underrun_cnt_q <= underrun_cnt_d;
`endif
        end
    end

    assign o_ready       = !hold_full_q;
    assign o_sdata       = sdata_q;
    assign o_frame_start = frame_start_q;
    assign o_underrun    = underrun_q;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    assign o_underrun_cnt = underrun_cnt_q;
`endif

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: 4-mclk sclk, 64-sclk frames, expected words hand-entered.
module tb_i2s_tx;

    localparam int unsigned DR = 24;
    localparam int unsigned SB = 32;

    logic          mclk = 1'b0;
    logic          reset;
    logic          next_sclk_fall, next_lrclk_fall, next_lrclk_rise;
    logic [DR-1:0] i_left, i_right;
    logic          i_valid;
    logic          o_ready, o_sdata, o_frame_start, o_underrun;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [15:0]   o_underrun_cnt;
`endif

    i2s_tx #(.DATA_RES(DR), .SLOT_BITS(SB)) dut (
        .mclk            (mclk),
        .reset           (reset),
        .next_sclk_fall  (next_sclk_fall),
        .next_lrclk_fall (next_lrclk_fall),
        .next_lrclk_rise (next_lrclk_rise),
        .i_left          (i_left),
        .i_right         (i_right),
        .i_valid         (i_valid),
        .o_ready         (o_ready),
        .o_sdata         (o_sdata),
        .o_frame_start   (o_frame_start),
`ifdef I2S_TX_UNDERRUN_CNT_EN
        .o_underrun      (o_underrun),
        .o_underrun_cnt  (o_underrun_cnt)
`else
        .o_underrun      (o_underrun)
`endif
    );

    initial forever #5 mclk = ~mclk;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            fs_cnt, ur_cnt, acc_cnt;
    logic [DR-1:0] ql[$];
    logic [DR-1:0] qr[$];
    logic [63:0]   bits;
    logic          ready_mid;
    logic          b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [DR-1:0] l, input logic [DR-1:0] r);
        ql.push_back(l);
        qr.push_back(r);
        if (!i_valid) begin
            i_left  = l;
            i_right = r;
            i_valid = 1'b1;
        end
    endtask

    task automatic step(input logic sf, input logic lf, input logic lr);
        logic acc;
        next_sclk_fall  = sf;
        next_lrclk_fall = lf;
        next_lrclk_rise = lr;
        acc = i_valid && o_ready && !reset;
        @(posedge mclk);
        #1;
        next_sclk_fall  = 1'b0;
        next_lrclk_fall = 1'b0;
        next_lrclk_rise = 1'b0;
        if (o_frame_start) fs_cnt++;
        if (o_underrun) ur_cnt++;
        if (acc) begin
            acc_cnt++;
            void'(ql.pop_front());
            void'(qr.pop_front());
            if (ql.size() > 0) begin
                i_left  = ql[0];
                i_right = qr[0];
            end else begin
                i_valid = 1'b0;
            end
        end
    endtask

    task automatic tick(input logic lf, input logic lr, input bit inj,
                        input logic [DR-1:0] il, input logic [DR-1:0] ir, output logic bo);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        if (inj) push(il, ir);
        step(1'b1, lf, lr);
        bo = o_sdata;
    endtask

    task automatic run_frame(input bit inj, input logic [DR-1:0] il, input logic [DR-1:0] ir);
        logic bo;
        fs_cnt  = 0;
        ur_cnt  = 0;
        acc_cnt = 0;
        for (int t = 0; t < 64; t++) begin
            tick(t == 0, t == 32, inj && (t == 0), il, ir, bo);
            bits[t] = bo;
            if (t == 10) ready_mid = o_ready;
        end
    endtask

    task automatic check_frame(input string tag, input logic [DR-1:0] el, input logic [DR-1:0] er,
                               input int efs, input int eur);
        logic [DR-1:0] gl, gr;
        logic          extra;
        gl    = '0;
        gr    = '0;
        extra = bits[0] | bits[32];
        for (int i = 1; i <= 24; i++) begin
            gl = {gl[DR-2:0], bits[i]};
            gr = {gr[DR-2:0], bits[32+i]};
        end
        for (int i = 25; i < 32; i++) extra = extra | bits[i] | bits[32+i];
        check({tag, "_left"},  32'(gl), 32'(el));
        check({tag, "_right"}, 32'(gr), 32'(er));
        check({tag, "_pad0"},  32'(extra), 32'd0);
        check({tag, "_fs"},    32'(fs_cnt), 32'(efs));
        check({tag, "_ur"},    32'(ur_cnt), 32'(eur));
    endtask

    initial begin
        reset = 1'b1;
        next_sclk_fall = 1'b0; next_lrclk_fall = 1'b0; next_lrclk_rise = 1'b0;
        i_left = '0; i_right = '0; i_valid = 1'b0;
        fs_cnt = 0; ur_cnt = 0; acc_cnt = 0; bits = '0; ready_mid = 1'b0;
        #1;
        repeat (3) step(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        check("rst_sdata", 32'(o_sdata), 32'd0);
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_fs", 32'(o_frame_start), 32'd0);
        check("rst_ur", 32'(o_underrun), 32'd0);
`ifdef I2S_TX_UNDERRUN_CNT_EN
        check("rst_cnt", 32'(o_underrun_cnt), 32'd0);
`endif

        // first frame out of SYNC carries a pair accepted beforehand
        push(24'hA5F00F, 24'h123456);
        repeat (2) step(1'b0, 1'b0, 1'b0);
        check("t1_ready_after_acc", 32'(o_ready), 32'd0);
        run_frame(1'b0, '0, '0);
        check_frame("t1", 24'hA5F00F, 24'h123456, 1, 0);
        check("t1_ready_mid", 32'(ready_mid), 32'd1);

        run_frame(1'b0, '0, '0);
        check_frame("t2", 24'h000000, 24'h000000, 0, 1);
        check("t2_allzero", 32'(|bits), 32'd0);
`ifdef I2S_TX_UNDERRUN_CNT_EN
        check("t2_cnt", 32'(o_underrun_cnt), 32'd1);
`endif

        push(24'h111111, 24'h222222);
        push(24'h333333, 24'h444444);
        push(24'h555555, 24'h666666);
        repeat (2) step(1'b0, 1'b0, 1'b0);
        run_frame(1'b0, '0, '0);
        check_frame("t3a", 24'h111111, 24'h222222, 1, 0);
        check("t3a_ready_mid", 32'(ready_mid), 32'd0);
        check("t3a_acc", 32'(acc_cnt), 32'd1);
        run_frame(1'b0, '0, '0);
        check_frame("t3b", 24'h333333, 24'h444444, 1, 0);
        check("t3b_ready_mid", 32'(ready_mid), 32'd0);
        check("t3b_acc", 32'(acc_cnt), 32'd1);
        run_frame(1'b0, '0, '0);
        check_frame("t3c", 24'h555555, 24'h666666, 1, 0);
        check("t3c_ready_mid", 32'(ready_mid), 32'd1);
        check("t3c_acc", 32'(acc_cnt), 32'd0);

        // accept lands on the same edge as the lrclk-fall commit
        run_frame(1'b1, 24'hABCDEF, 24'h654321);
        check_frame("t4a", 24'h000000, 24'h000000, 0, 1);
        check("t4a_acc", 32'(acc_cnt), 32'd1);
        run_frame(1'b0, '0, '0);
        check_frame("t4b", 24'hABCDEF, 24'h654321, 1, 0);
`ifdef I2S_TX_UNDERRUN_CNT_EN
        check("t4_cnt", 32'(o_underrun_cnt), 32'd2);
`endif

        push(24'hC3C3C3, 24'h5A5A5A);
        repeat (2) step(1'b0, 1'b0, 1'b0);
        push(24'h0F0F0F, 24'hF0F0F0);
        for (int t = 0; t <= 10; t++) tick(t == 0, 1'b0, 1'b0, '0, '0, b);
        check("t5_bit10", 32'(b), 32'd1);
        check("t5_ready_full", 32'(o_ready), 32'd0);
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        check("t5_rst_sdata", 32'(o_sdata), 32'd0);
        check("t5_rst_ready", 32'(o_ready), 32'd1);
`ifdef I2S_TX_UNDERRUN_CNT_EN
        check("t5_rst_cnt", 32'(o_underrun_cnt), 32'd0);
`endif
        fs_cnt = 0; ur_cnt = 0;
        bits = '0;
        for (int t = 11; t < 64; t++) begin
            tick(1'b0, t == 32, 1'b0, '0, '0, b);
            bits[t] = b;
        end
        check("t5_sync_zero", 32'(|bits), 32'd0);
        check("t5_sync_fs", 32'(fs_cnt), 32'd0);
        check("t5_sync_ur", 32'(ur_cnt), 32'd0);
        push(24'h96ACE1, 24'h1EDCBA);
        repeat (2) step(1'b0, 1'b0, 1'b0);
        run_frame(1'b0, '0, '0);
        check_frame("t5r", 24'h96ACE1, 24'h1EDCBA, 1, 0);

`ifdef I2S_TX_UNDERRUN_CNT_EN
        force dut.underrun_cnt_q = 16'hFFFE;
        #1;
        release dut.underrun_cnt_q;
        run_frame(1'b0, '0, '0);
        check("t6_cnt_max", 32'(o_underrun_cnt), 32'h0000FFFF);
        run_frame(1'b0, '0, '0);
        check("t6_cnt_sat", 32'(o_underrun_cnt), 32'h0000FFFF);
        check("t6_ur", 32'(ur_cnt), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- I2S serial transmitter, counterpart of the I2S receive path; runs entirely on mclk.
- Accepts stereo sample pairs over a valid/ready handshake into a one-deep holding buffer, then serialises left and right words MSB-first on o_sdata.
- Uses the codec's sclk/lrclk edge strobes from the shared clock generator.
- Standard I2S timing: MSB one sclk after the lrclk edge, lrclk low = left.

Parameters:
- DATA_RES, 24, sample width in bits per channel.
- SLOT_BITS, 32, sclk periods per channel slot; must be >= DATA_RES+1.

Ports:
- mclk  input  1  master clock; all logic on posedge.
- reset  input  1  synchronous, active-high.
- next_sclk_fall  input  1  one-mclk pulse; sclk falls at the end of this mclk cycle.
- next_lrclk_fall  input  1  one-mclk pulse; lrclk falls (left slot starts) at the end of this cycle; always coincident with next_sclk_fall.
- next_lrclk_rise  input  1  as above; right slot starts; always coincident with next_sclk_fall.
- i_left  input  DATA_RES  left sample, two's complement.
- i_right  input  DATA_RES  right sample.
- i_valid  input  1  sample pair valid.
- o_ready  output  1  holding buffer empty.
- o_sdata  output  1  serial data to codec, registered.
- o_frame_start  output  1  one-mclk pulse when a pair is committed to the shifters.
- o_underrun  output  1  one-mclk pulse when a frame starts with the buffer empty.

Behaviour:
- Reset values: o_sdata=0, o_ready=1, o_frame_start=0, o_underrun=0. Holding buffer empty, shifters zero, slot counter=SLOT_BITS-1, state SYNC.
- Handshake: transfer on any mclk edge with i_valid && o_ready. The pair is latched into the holding buffer; hold_full=1.
- o_ready = !hold_full, registered. Ready drops the cycle after acceptance and is never combinationally dependent on i_valid.
- States:
  - SYNC: o_sdata held 0; ignores next_lrclk_rise. On next_lrclk_fall go to LEFT.
  - LEFT: on next_lrclk_rise go to RIGHT.
  - RIGHT: on next_lrclk_fall go to LEFT.
- Frame commit, on every next_lrclk_fall that enters LEFT:
  - hold_full=1: copy buffer to left/right shifters, clear hold_full, pulse o_frame_start.
  - hold_full=0: load zeros into both shifters, pulse o_underrun, no o_frame_start.
- Simultaneous accept and next_lrclk_fall with buffer empty: commit sees the empty buffer, so underrun fires and zeros are sent. The new pair lands in the buffer for the next frame.
- Slot counter: set to 0 on next_lrclk_fall or next_lrclk_rise; otherwise +1 on each next_sclk_fall, saturating at SLOT_BITS-1.
- o_sdata updates only on mclk edges where next_sclk_fall=1, so data changes with sclk's falling edge. Value driven for new counter value k:
  - k=0: 0.
  - 1<=k<=DATA_RES: bit DATA_RES-k of the active channel's shifter (left in LEFT, right in RIGHT).
  - k>DATA_RES: 0.
- Latency: MSB appears on o_sdata at the first next_sclk_fall after the lrclk edge. The LSB appears at the DATA_RES-th.
- next_lrclk_rise while in SYNC: ignored, output stays 0.
- Reset asserted mid-frame: all state returns to reset values the next edge. o_sdata goes to 0 immediately and stays 0 until the next next_lrclk_fall. The buffered sample is discarded.
- Strobes with no next_sclk_fall: no shift or counter change.

Optional Feature:
- Macro: I2S_TX_UNDERRUN_CNT_EN.
- Defined: adds output o_underrun_cnt [15:0], reset 0. It increments on each o_underrun pulse, saturates at 16'hFFFF, and clears only on reset.
- Undefined: the port and counter do not exist; o_underrun pulse behaviour is unchanged.

Test Plan:
- Reset, then accept i_left=24'hA5F00F, i_right=24'h123456 before the first lrclk fall. Required: left slot bits 1..24 serialise 1010_0101_1111_0000_0000_1111; right slot serialises 24'h123456; slot bits 0 and 25..31 are 0; one o_frame_start.
- No sample supplied for a frame. Required: o_underrun pulses once, o_sdata is 0 for all 64 sclk periods, and with the macro o_underrun_cnt=1.
- Back-to-back pairs each frame with i_valid held high, three frames. Required: o_ready low from acceptance until commit, three o_frame_start pulses, zero underruns, correct data order.
- Pair accepted the same cycle as next_lrclk_fall with buffer empty. Required: zeros and an underrun pulse that frame; the pair is transmitted the following frame.
- Reset asserted at left slot bit 10. Required: o_sdata=0 the next edge; next_lrclk_rise is ignored; transmission resumes only after the next lrclk fall with a newly supplied pair.
- Macro defined, forcing 65537 underruns via a force on the counter near 16'hFFFE. Required: counter saturates at 16'hFFFF.
